register_file_dump: RTL
=======================

# register_file_dump

Read-side debug engine for the 32×32 register file. On a start pulse it walks every register through one read port and streams each entry out as a 5-byte frame (index byte, then data MSB-first) over a valid/ready byte interface. It sits beside the register file in the FPGA top level and feeds a UART transmitter or display driver. It is the observation counterpart of the switch-driven write path.

## Interface
Parameters:
- NREGS, 32, number of registers dumped (indices 0..NREGS-1)

Ports (clock and reset first):
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- start  in  1  begin dump; sampled only in IDLE
- rsel  out  5  read select to register file (rsel1 or rsel2)
- rdat  in  32  combinational read data for rsel
- byte_out  out  8  stream data
- byte_valid  out  1  byte_out holds a byte
- byte_ready  in  1  sink accepts byte when valid & ready
- busy  out  1  high from LOAD of reg 0 through DONE
- done  out  1  one-cycle pulse at end of dump

## Operation
- Reset values: state IDLE, idx 0, cnt 0, rsel 0, byte_out 0, byte_valid 0, busy 0, done 0.
- rsel is a register that always equals idx.
- States:
  - IDLE: start=1 -> LOAD, idx=0, cnt=0. Otherwise stay.
  - LOAD: word <= rdat (value of register idx), cnt=0 -> SEND.
  - SEND: byte_valid=1. byte_out = {3'b0, idx} for cnt 0; word[31:24], [23:16], [15:8], [7:0] for cnt 1..4.
    - On valid & ready with cnt<4: cnt++.
    - On valid & ready with cnt==4: if idx==NREGS-1 -> DONE, else idx++ -> LOAD.
  - DONE: done=1 for one cycle -> IDLE. busy stays high in this cycle.
- word is captured once per register in LOAD. Writes to that register during SEND do not change the bytes being sent.
- byte_out and byte_valid are stable while valid & !ready.
- start while not in IDLE is ignored. It is not queued.
- Register 0 reads as zero from the register file and is sent as 00 00 00 00 00.
- RST asserted mid-dump aborts immediately to the reset values. No partial frame resumes.

## Timing
- Start sampled at edge 0: LOAD in cycle 1, first byte valid in cycle 2.
- With byte_ready held high:
  - each register takes 6 cycles (1 LOAD + 5 SEND);
  - last LOAD is in cycle 187, DONE is cycle 193, IDLE from cycle 194.
- Each cycle with byte_ready low during SEND adds exactly one cycle.
- No combinational path from byte_ready to byte_out or byte_valid. All outputs are registered or decoded from state.

## Structure
- word_t (32-bit) and regbits_t (5-bit) come from the shared cpu_types_pkg.
- The state enum (IDLE, LOAD, SEND, DONE) is local to the module and not exported.
- No sub-module: the byte mux is a 5-way select on cnt inside this block.
- FPGA top level:
  - start from an edge-detected KEY;
  - rsel drives rfif.rsel2 while busy; switches drive it otherwise;
  - stream goes to the UART TX.

## Test plan
- Preload reg 5 = 0xDEADBEEF, reg 31 = 0x12345678, others = 0. Pulse start, byte_ready=1.
  -> frame 5 is 05 DE AD BE EF; frame 31 is 1F 12 34 56 78; done pulses in cycle 193.
- Write 0xFFFFFFFF to reg 0, then dump -> first frame is 00 00 00 00 00.
- Hold byte_ready=0 for 3 cycles on byte 2 of reg 1 (value 0xA5A5A5A5).
  -> byte_out stays 0xA5 and byte_valid stays 1 throughout; total dump is 3 cycles longer.
- Reg 7 = 0x11111111. Write 0x22222222 to reg 7 while its frame is in SEND.
  -> frame still reads 07 11 11 11 11.
- Pulse start again at cycle 50 of an active dump -> ignored; exactly 32 frames emitted, one done pulse.
- Assert RST during reg 10's frame -> byte_valid, busy, done go 0 asynchronously; rsel=0. A new start restarts from index 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types used by the register file and its debug dump engine.
//   word_t     : one 32-bit register file entry
//   regbits_t  : register index / read-select width (32 registers)
//   frame_byte : selects byte <cnt> of a dump frame (index byte, then data MSB-first)
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  // A frame is one index byte followed by the four data bytes.
  localparam int FRAME_BYTES = 5;

  function automatic logic [7:0] frame_byte(
    input logic [2:0] cnt,
    input regbits_t   idx,
    input word_t      word
  );
    logic [7:0] b;
    case (cnt)
      3'd0:    b = {3'b000, idx};
      3'd1:    b = word[31:24];
      3'd2:    b = word[23:16];
      3'd3:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/register_file_dump.sv
// register_file_dump: walks registers 0..NREGS-1 through one register file
// read port and streams each as a 5-byte frame (index, data MSB-first).
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous active-high reset
//   start       in   begin a dump, only honoured in IDLE
//   rsel        out  read select to the register file (always equals idx)
//   rdat        in   combinational read data for rsel
//   byte_out    out  stream byte
//   byte_valid  out  byte_out holds a byte
//   byte_ready  in   sink accepts the byte when valid & ready
//   busy        out  high from the first LOAD through DONE
//   done        out  one-cycle pulse at the end of a dump
//   dbg_state_o out  current FSM state (0 IDLE, 1 LOAD, 2 SEND, 3 DONE)
//
// Handshake: byte_valid/byte_out are decoded purely from registered state, so
// they never depend combinationally on byte_ready; a byte is transferred on
// the rising edge where byte_valid & byte_ready, and the presented byte holds
// unchanged for as long as byte_ready stays low.
module register_file_dump
  import cpu_types_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output regbits_t    rsel,
  input  word_t       rdat,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam regbits_t LAST_IDX = regbits_t'(NREGS - 1);
  localparam logic [2:0] LAST_CNT = 3'(FRAME_BYTES - 1);

  state_e     state_q, state_d;
  regbits_t   idx_q, idx_d;
  logic [2:0] cnt_q, cnt_d;
  word_t      word_q, word_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        // Snapshot once per register so later writes cannot tear the frame.
        word_d  = rdat;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (byte_ready) begin
          if (cnt_q != LAST_CNT) begin
            cnt_d = cnt_q + 3'd1;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // rsel is the idx register itself, so the read port is set up a full cycle
  // before LOAD samples rdat.
  assign rsel        = idx_q;
  assign byte_valid  = (state_q == S_SEND);
  assign byte_out    = (state_q == S_SEND) ? frame_byte(cnt_q, idx_q, word_q) : 8'h00;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule
